alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
//
// PURPOSE
//   Registered output stage directly downstream of the logic-unit result mux.
//   - Captures each result word (e_o of the logic circuit) with the opcode that produced it.
//   - Computes a zero flag and stores it with the result.
//   - Presents result, opcode and flag to the consumer over a valid/ready handshake.
//   - A 2-entry skid buffer keeps the upstream ready path registered.
//
// PARAMETERS
//   WIDTH      1  result data width; matches the WIDTH of the logic circuit it follows
//   CNT_WIDTH  8  width of the delivered-result counter
//
// PORTS
//   clk_i    in   1          single clock, rising edge
//   rst_i    in   1          asynchronous reset, active-high
//   res_i    in   WIDTH      result word from the logic circuit
//   op_i     in   2          opcode (sel_i) that produced res_i: 00 AND, 01 OR, 10 XOR, 11 NOT
//   valid_i  in   1          res_i/op_i valid this cycle
//   ready_o  out  1          stage can accept this cycle (registered)
//   res_o    out  WIDTH      buffered result
//   op_o     out  2          opcode belonging to res_o
//   zero_o   out  1          1 when res_o == 0
//   valid_o  out  1          res_o/op_o/zero_o valid
//   ready_i  in   1          consumer accepts this cycle
//   cnt_o    out  CNT_WIDTH  count of results delivered since reset
//
// BEHAVIOUR
//   - Reset (async assert, sync release):
//     - valid_o=0, ready_o=1, res_o=0, op_o=0, zero_o=0, cnt_o=0.
//     - Both buffer entries are emptied; any data in flight is discarded, including mid-transfer.
//   - Transfer events:
//     - Accept = valid_i & ready_o.
//     - Deliver = valid_o & ready_i.
//     - Both are evaluated at the same rising edge.
//   - Entries:
//     - MAIN drives the outputs; SKID is the overflow entry.
//     - Each entry holds {res, op, zero}, with zero = (res == 0) computed at capture time.
//   - FSM states (the 2-bit state may be coded freely):
//     - EMPTY: accept -> load MAIN, go ONE; otherwise stay.
//     - ONE, accept & deliver: load MAIN with new data, stay ONE.
//     - ONE, accept & !deliver: load SKID, go FULL.
//     - ONE, !accept & deliver: go EMPTY.
//     - ONE, neither: hold.
//     - FULL: deliver -> MAIN <= SKID, go ONE; otherwise hold. Accept cannot occur (ready_o=0).
//   - Outputs:
//     - valid_o = (state != EMPTY).
//     - ready_o = (state != FULL), registered from the next state; no combinational path from ready_i.
//   - Latency: data accepted at edge N is on res_o with valid_o=1 after edge N (one cycle) when EMPTY.
//     Throughput is 1 word/cycle while ready_i=1.
//   - Ordering: strict FIFO; no word is dropped or duplicated.
//   - Stall: while valid_o=1 & ready_i=0, res_o/op_o/zero_o are held stable.
//   - Counter: cnt_o increments by 1 on each deliver and wraps from 2^CNT_WIDTH-1 to 0.
//   - Upstream rule: valid_i asserted with ready_o=0 is ignored.
//     Upstream must hold res_i/op_i until accepted.
//
// TESTING
//   1. Reset with ready_i=1: pulse rst_i mid-cycle.
//      -> All outputs take reset values immediately; ready_o=1, cnt_o=0.
//   2. Single word, WIDTH=4: res_i=4'hA, op_i=2'b10, valid_i=1 for 1 cycle.
//      -> Next cycle res_o=4'hA, op_o=2'b10, zero_o=0, valid_o=1; after deliver cnt_o=1, valid_o=0.
//   3. Back-to-back, ready_i=1: words 1,2,3,0 on consecutive cycles.
//      -> Same order out, one per cycle; zero_o=1 only with word 0; cnt_o=4.
//   4. Stall with ready_i=0: send words 5,6.
//      -> ready_o drops to 0 after the 2nd accept; res_o holds 5.
//      -> Raise ready_i: 5 then 6 delivered; ready_o returns to 1.
//   5. Simultaneous accept+deliver in ONE, continuous valid_i and ready_i for 16 cycles.
//      -> State stays ONE, no bubbles, output stream equals input stream delayed 1 cycle.
//   6. Counter wrap, CNT_WIDTH=2: deliver 5 words -> cnt_o sequence 1,2,3,0,1.
//      Also: assert rst_i while FULL -> buffer empties, no stale word reappears after release.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered output stage for the logic-unit result: captures result, opcode and zero flag
// in a 2-entry skid buffer and hands them to the consumer over valid/ready.
module alu_result_stage #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIDTH-1:0]     res_i,
    input  logic [1:0]           op_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [WIDTH-1:0]     res_o,
    output logic [1:0]           op_o,
    output logic                 zero_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [1:0]       op;
        logic             zero;
    } entry_t;

    state_t               state_q;
    entry_t               main_q;
    entry_t               skid_q;
    entry_t               in_entry;
    logic                 ready_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 accept;
    logic                 deliver;

    // The zero flag travels with the word so the consumer never sees a recomputed value.
    assign in_entry = '{res: res_i, op: op_i, zero: (res_i == '0)};

    assign valid_o = (state_q != ST_EMPTY);
    assign accept  = valid_i & ready_q;
    assign deliver = valid_o & ready_i;

    // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            // NOTE: both entries are cleared because MAIN drives the outputs, which must read 0 in reset.
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q  <= in_entry;
                        state_q <= ST_ONE;
                    end
                    ready_q <= 1'b1;
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        main_q  <= in_entry;
                        ready_q <= 1'b1;
                    end else if (accept) begin
                        skid_q  <= in_entry;
                        state_q <= ST_FULL;
                        ready_q <= 1'b0;
                    end else if (deliver) begin
                        state_q <= ST_EMPTY;
                        ready_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    // ready_o is low here, so only the drain side can move.
                    if (deliver) begin
                        main_q  <= skid_q;
                        state_q <= ST_ONE;
                        ready_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (deliver) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign ready_o = ready_q;
    assign res_o   = main_q.res;
    assign op_o    = main_q.op;
    assign zero_o  = main_q.zero;
    assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: one 8-bit-counter instance and one 2-bit-counter
// instance driven by the same stimulus.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] res_i;
    logic [1:0] op_i;
    logic       valid_i;
    logic       ready_i;

    logic       ready_o, zero_o, valid_o;
    logic [3:0] res_o;
    logic [1:0] op_o;
    logic [7:0] cnt_o;

    logic       w_ready_o, w_zero_o, w_valid_o;
    logic [3:0] w_res_o;
    logic [1:0] w_op_o;
    logic [1:0] w_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(4), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .res_i(res_i), .op_i(op_i), .valid_i(valid_i),
        .ready_o(ready_o), .res_o(res_o), .op_o(op_o), .zero_o(zero_o),
        .valid_o(valid_o), .ready_i(ready_i), .cnt_o(cnt_o)
    );

    alu_result_stage #(.WIDTH(4), .CNT_WIDTH(2)) dut_w (
        .clk_i(clk), .rst_i(rst), .res_i(res_i), .op_i(op_i), .valid_i(valid_i),
        .ready_o(w_ready_o), .res_o(w_res_o), .op_o(w_op_o), .zero_o(w_zero_o),
        .valid_o(w_valid_o), .ready_i(ready_i), .cnt_o(w_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_ready"}, 32'(ready_o), 32'd1);
        check({tag, "_res"},   32'(res_o),   32'd0);
        check({tag, "_op"},    32'(op_o),    32'd0);
        check({tag, "_zero"},  32'(zero_o),  32'd0);
        check({tag, "_cnt"},   32'(cnt_o),   32'd0);
        check({tag, "_wcnt"},  32'(w_cnt_o), 32'd0);
    endtask

    initial begin
        logic [3:0] words3 [4];
        logic [1:0] wrap_seq [5];
        logic [3:0] exp_w;

        rst     = 1'b1;
        res_i   = '0;
        op_i    = '0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: load a word into the stage, then pulse reset mid-cycle
        ready_i = 1'b0;
        res_i   = 4'h3;
        op_i    = 2'b01;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("t1_loaded_valid", 32'(valid_o), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("t1_async");
        tick();
        rst     = 1'b0;
        ready_i = 1'b1;
        tick();
        check_reset_outputs("t1_release");

        // 2: single word
        res_i   = 4'hA;
        op_i    = 2'b10;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("t2_res",   32'(res_o),   32'hA);
        check("t2_op",    32'(op_o),    32'd2);
        check("t2_zero",  32'(zero_o),  32'd0);
        check("t2_valid", 32'(valid_o), 32'd1);
        tick();
        check("t2_valid_after", 32'(valid_o), 32'd0);
        check("t2_cnt",         32'(cnt_o),   32'd1);

        // 3: back-to-back 1,2,3,0
        do_reset();
        words3 = '{4'h1, 4'h2, 4'h3, 4'h0};
        for (int i = 0; i < 4; i++) begin
            res_i   = words3[i];
            op_i    = 2'(i);
            valid_i = 1'b1;
            tick();
            check("t3_res",   32'(res_o),   32'(words3[i]));
            check("t3_op",    32'(op_o),    32'(i));
            check("t3_zero",  32'(zero_o),  (i == 3) ? 32'd1 : 32'd0);
            check("t3_valid", 32'(valid_o), 32'd1);
        end
        valid_i = 1'b0;
        tick();
        check("t3_valid_end", 32'(valid_o), 32'd0);
        check("t3_cnt",       32'(cnt_o),   32'd4);
        check("t3_wcnt",      32'(w_cnt_o), 32'd0);

        // 4: stall, fill to FULL, then drain
        do_reset();
        ready_i = 1'b0;
        res_i   = 4'h5;
        op_i    = 2'b00;
        valid_i = 1'b1;
        tick();
        check("t4_ready_one", 32'(ready_o), 32'd1);
        check("t4_res_one",   32'(res_o),   32'h5);
        res_i = 4'h6;
        op_i  = 2'b11;
        tick();
        check("t4_ready_full", 32'(ready_o), 32'd0);
        check("t4_res_full",   32'(res_o),   32'h5);
        res_i = 4'h7;
        tick();
        check("t4_ready_hold", 32'(ready_o), 32'd0);
        check("t4_res_hold",   32'(res_o),   32'h5);
        check("t4_op_hold",    32'(op_o),    32'd0);
        check("t4_cnt_hold",   32'(cnt_o),   32'd0);
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check("t4_res_second", 32'(res_o),   32'h6);
        check("t4_op_second",  32'(op_o),    32'd3);
        check("t4_ready_back", 32'(ready_o), 32'd1);
        check("t4_cnt_one",    32'(cnt_o),   32'd1);
        tick();
        check("t4_valid_end",  32'(valid_o), 32'd0);
        check("t4_cnt_two",    32'(cnt_o),   32'd2);

        // 5: continuous stream, one word per cycle
        do_reset();
        valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_w = 4'(i) ^ 4'h9;
            res_i = exp_w;
            op_i  = 2'(i % 4);
            tick();
            check("t5_res",   32'(res_o),   32'(exp_w));
            check("t5_op",    32'(op_o),    32'(i % 4));
            check("t5_zero",  32'(zero_o),  (exp_w == 4'h0) ? 32'd1 : 32'd0);
            check("t5_valid", 32'(valid_o), 32'd1);
            check("t5_ready", 32'(ready_o), 32'd1);
            check("t5_cnt",   32'(cnt_o),   32'(i));
        end
        valid_i = 1'b0;
        tick();
        check("t5_cnt_end",  32'(cnt_o),   32'd16);
        check("t5_wcnt_end", 32'(w_cnt_o), 32'd0);

        // 6: 2-bit counter wrap, then reset while FULL
        do_reset();
        wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            res_i   = 4'(i + 1);
            op_i    = 2'b01;
            valid_i = 1'b1;
            tick();
            valid_i = 1'b0;
            check("t6_wres", 32'(w_res_o), 32'(i + 1));
            tick();
            check("t6_wcnt", 32'(w_cnt_o), 32'(wrap_seq[i]));
        end
        ready_i = 1'b0;
        res_i   = 4'h8;
        valid_i = 1'b1;
        tick();
        res_i = 4'h9;
        tick();
        valid_i = 1'b0;
        check("t6_full_ready", 32'(w_ready_o), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(w_valid_o), 32'd0);
        check("t6_rst_ready", 32'(w_ready_o), 32'd1);
        check("t6_rst_res",   32'(w_res_o),   32'd0);
        tick();
        rst     = 1'b0;
        ready_i = 1'b1;
        tick();
        tick();
        check("t6_no_stale_valid", 32'(w_valid_o), 32'd0);
        check("t6_no_stale_cnt",   32'(w_cnt_o),   32'd0);
        res_i   = 4'hC;
        op_i    = 2'b10;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("t6_fresh_res", 32'(w_res_o), 32'hC);
        tick();
        check("t6_fresh_valid", 32'(w_valid_o), 32'd0);
        check("t6_fresh_cnt",   32'(w_cnt_o),   32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
